irq_dispatcher: RTL and testbench

- Consumer end of the interrupt path. Sits between the clocked priority encoder and the CPU core.
- Accepts the encoder's IRQ flag and 2-bit winning vector, then runs a request/acknowledge/end-of-interrupt handshake with the CPU.
- On completion it decodes the serviced vector back into a one-hot acknowledge pulse to the originating source, which clears that source's pending request.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_dispatcher_vec_decoder.sv | 20 ++
 rtl/irq_dispatcher.sv | 149 ++++++++++++++
 tb/tb_irq_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt dispatcher.
// Single-cycle, no backpressure; pure declarations.
// The optional IRQ_TIMEOUT_EN feature uses ACK_TIMEOUT_DEF.
package irq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SERVICE = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_WAIT    = 3'd4
    } state_t;

    localparam int N_SRC_DEF       = 4;
    localparam int VEC_W_DEF       = 2;
    localparam int HOLDOFF_DEF     = 2;
    localparam int ACK_TIMEOUT_DEF = 255;

endpackage

// File: rtl/irq_dispatcher_vec_decoder.sv
// Vector to one-hot decoder with enable.
// Combinational, zero latency.
// No backpressure; the output is all zeros while disabled.
module vec_decoder #(
    parameter int VEC_W = 2,
    parameter int N_SRC = 4
) (
    input  logic             en,
    input  logic [VEC_W-1:0] vec,
    output logic [N_SRC-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = N_SRC'(1) << vec;
        end
    end

endmodule

// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: encoder flag/vector to CPU req/ack/eoi handshake, then one-hot source clear.
// Latency 1 clock from a sampled irq_in to cpu_irq. The CPU throttles progress via cpu_ack/cpu_eoi.
// Optional macro IRQ_TIMEOUT_EN adds an 8-bit ack timeout that aborts through WAIT.
module irq_dispatcher
    import irq_pkg::*;
#(
    parameter int N_SRC       = N_SRC_DEF,
    parameter int VEC_W       = VEC_W_DEF,
    parameter int HOLDOFF     = HOLDOFF_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irq_in,
    input  logic [VEC_W-1:0] vec_in,
    input  logic [N_SRC-1:0] mask,
    input  logic             cpu_ack,
    input  logic             cpu_eoi,
    output logic             cpu_irq,
    output logic [VEC_W-1:0] cpu_vector,
    output logic [N_SRC-1:0] src_ack,
    output logic             busy,
    output logic             timeout_err
);

    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    if (VEC_W != $clog2(N_SRC)) begin : g_bad_vec_w
        $error("VEC_W must equal clog2(N_SRC)");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
        $error("ACK_TIMEOUT must fit the 8-bit timeout counter");
    end
    if (HOLDOFF < 0) begin : g_bad_holdoff
        $error("HOLDOFF must be non-negative");
    end

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    cur_vec_q, cur_vec_d;
    logic                cpu_irq_q, cpu_irq_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N_SRC-1:0]    src_ack_q, src_ack_d;
    logic                busy_q, busy_d;
    logic                vec_ok;

`ifdef IRQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       timeout_err_q, timeout_err_d;
`endif

    // Out-of-range vectors behave exactly like masked sources.
    assign vec_ok = (int'(vec_in) < N_SRC);

    always_comb begin
        state_d   = state_q;
        cur_vec_d = cur_vec_q;
        cpu_irq_d = cpu_irq_q;
        hold_d    = hold_q;
`ifdef IRQ_TIMEOUT_EN
        timeout_err_d = 1'b0;
        to_cnt_d      = (state_q == ST_REQ) ? to_cnt_q + 8'd1 : 8'd0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (irq_in && vec_ok && !mask[vec_in]) begin
                    state_d   = ST_REQ;
                    cur_vec_d = vec_in;
                    cpu_irq_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (cpu_ack) begin
                    state_d   = ST_SERVICE;
                    cpu_irq_d = 1'b0;
                end
`ifdef IRQ_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d       = ST_WAIT;
                    cpu_irq_d     = 1'b0;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            ST_SERVICE: begin
                if (cpu_eoi) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR, ST_WAIT: begin
                state_d = ST_IDLE;
                hold_d  = HOLD_W'(HOLDOFF);
            end
            default: begin
                state_d   = ST_IDLE;
                cpu_irq_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    vec_decoder #(
        .VEC_W (VEC_W),
        .N_SRC (N_SRC)
    ) u_vec_decoder (
        .en     (state_d == ST_CLEAR),
        .vec    (cur_vec_q),
        .onehot (src_ack_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_vec_q <= '0;
            cpu_irq_q <= 1'b0;
            hold_q    <= '0;
            src_ack_q <= '0;
            busy_q    <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
            to_cnt_q      <= 8'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cur_vec_q <= cur_vec_d;
            cpu_irq_q <= cpu_irq_d;
            hold_q    <= hold_d;
            src_ack_q <= src_ack_d;
            busy_q    <= busy_d;
`ifdef IRQ_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign cpu_irq    = cpu_irq_q;
    assign cpu_vector = cur_vec_q;
    assign src_ack    = src_ack_q;
    assign busy       = busy_q;
`ifdef IRQ_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_irq_dispatcher.sv
// Directed self-checking bench for irq_dispatcher; the timeout scenario follows IRQ_TIMEOUT_EN.
module tb_irq_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       irq_in;
    logic [1:0] vec_in;
    logic [3:0] mask;
    logic       cpu_ack;
    logic       cpu_eoi;
    logic       cpu_irq;
    logic [1:0] cpu_vector;
    logic [3:0] src_ack;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // {cpu_irq, cpu_vector, src_ack, busy, timeout_err}
    logic [8:0] obs;
    assign obs = {cpu_irq, cpu_vector, src_ack, busy, timeout_err};

    irq_dispatcher #(
        .N_SRC       (4),
        .VEC_W       (2),
        .HOLDOFF     (2),
        .ACK_TIMEOUT (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .vec_in      (vec_in),
        .mask        (mask),
        .cpu_ack     (cpu_ack),
        .cpu_eoi     (cpu_eoi),
        .cpu_irq     (cpu_irq),
        .cpu_vector  (cpu_vector),
        .src_ack     (src_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_in = 1'b1; vec_in = 2'd2; mask = 4'b0000;
        cpu_ack = 1'b0; cpu_eoi = 1'b0;
        step(); step();
        checks++;
        if (obs !== 9'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", obs, 9'b0);
        end
        mask = 4'b0100; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== 9'b0) begin
                errors++; $display("FAIL reset_masked_idle[%0d]: got %b want %b", i, obs, 9'b0);
            end
        end
    endtask

    task automatic test_handshake();
        mask = 4'b0000;
        step();
        checks++;
        if (obs !== {1'b1, 2'd2, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL hs_req: got %b want %b", obs, {1'b1, 2'd2, 4'b0000, 1'b1, 1'b0});
        end
        vec_in = 2'd0; mask = 4'b1111;
        step();
        checks++;
        if (obs !== {1'b1, 2'd2, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL hs_req_stable: got %b want %b", obs, {1'b1, 2'd2, 4'b0000, 1'b1, 1'b0});
        end
        vec_in = 2'd2; mask = 4'b0000; cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        checks++;
        if (obs !== {1'b0, 2'd2, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL hs_service: got %b want %b", obs, {1'b0, 2'd2, 4'b0000, 1'b1, 1'b0});
        end
        step();
        checks++;
        if (obs !== {1'b0, 2'd2, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL hs_service_hold: got %b want %b", obs, {1'b0, 2'd2, 4'b0000, 1'b1, 1'b0});
        end
        cpu_eoi = 1'b1;
        step();
        cpu_eoi = 1'b0;
        checks++;
        if (obs !== {1'b0, 2'd2, 4'b0100, 1'b1, 1'b0}) begin
            errors++; $display("FAIL hs_clear: got %b want %b", obs, {1'b0, 2'd2, 4'b0100, 1'b1, 1'b0});
        end
        step();
        checks++;
        if (obs !== {1'b0, 2'd2, 4'b0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL hs_idle: got %b want %b", obs, {1'b0, 2'd2, 4'b0000, 1'b0, 1'b0});
        end
    endtask

    task automatic test_holdoff();
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== {1'b0, 2'd2, 4'b0000, 1'b0, 1'b0}) begin
                errors++; $display("FAIL holdoff_quiet[%0d]: got %b want %b", i, obs, {1'b0, 2'd2, 4'b0000, 1'b0, 1'b0});
            end
        end
        step();
        checks++;
        if (obs !== {1'b1, 2'd2, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL holdoff_rearm: got %b want %b", obs, {1'b1, 2'd2, 4'b0000, 1'b1, 1'b0});
        end
    endtask

    task automatic test_simultaneous();
        cpu_ack = 1'b1; cpu_eoi = 1'b1;
        step();
        cpu_ack = 1'b0; cpu_eoi = 1'b0;
        checks++;
        if (obs !== {1'b0, 2'd2, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL simul_ack_eoi: got %b want %b", obs, {1'b0, 2'd2, 4'b0000, 1'b1, 1'b0});
        end
        step();
        checks++;
        if (obs !== {1'b0, 2'd2, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL simul_still_service: got %b want %b", obs, {1'b0, 2'd2, 4'b0000, 1'b1, 1'b0});
        end
        cpu_eoi = 1'b1;
        step();
        cpu_eoi = 1'b0; irq_in = 1'b0;
        checks++;
        if (obs !== {1'b0, 2'd2, 4'b0100, 1'b1, 1'b0}) begin
            errors++; $display("FAIL simul_clear: got %b want %b", obs, {1'b0, 2'd2, 4'b0100, 1'b1, 1'b0});
        end
        step();
    endtask

    task automatic test_stray();
        cpu_ack = 1'b1; cpu_eoi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {1'b0, 2'd2, 4'b0000, 1'b0, 1'b0}) begin
                errors++; $display("FAIL stray_idle[%0d]: got %b want %b", i, obs, {1'b0, 2'd2, 4'b0000, 1'b0, 1'b0});
            end
        end
        cpu_ack = 1'b0; cpu_eoi = 1'b0;
    endtask

    task automatic test_mask();
        irq_in = 1'b1; vec_in = 2'd1; mask = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {1'b0, 2'd2, 4'b0000, 1'b0, 1'b0}) begin
                errors++; $display("FAIL mask_blocked[%0d]: got %b want %b", i, obs, {1'b0, 2'd2, 4'b0000, 1'b0, 1'b0});
            end
        end
        mask = 4'b0000;
        step();
        checks++;
        if (obs !== {1'b1, 2'd1, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mask_unblocked: got %b want %b", obs, {1'b1, 2'd1, 4'b0000, 1'b1, 1'b0});
        end
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0; cpu_eoi = 1'b1;
        step();
        cpu_eoi = 1'b0; irq_in = 1'b0;
        checks++;
        if (obs !== {1'b0, 2'd1, 4'b0010, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mask_src_ack1: got %b want %b", obs, {1'b0, 2'd1, 4'b0010, 1'b1, 1'b0});
        end
        step();
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; irq_in = 1'b1; vec_in = 2'd3;
        step();
        checks++;
        if (obs !== {1'b1, 2'd3, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rmid_req3: got %b want %b", obs, {1'b1, 2'd3, 4'b0000, 1'b1, 1'b0});
        end
        irq_in = 1'b0; cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        rst_n = 1'b0; cpu_eoi = 1'b1;
        step();
        checks++;
        if (obs !== 9'b0) begin
            errors++; $display("FAIL rmid_reset: got %b want %b", obs, 9'b0);
        end
        cpu_eoi = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== 9'b0) begin
                errors++; $display("FAIL rmid_no_ack[%0d]: got %b want %b", i, obs, 9'b0);
            end
        end
    endtask

`ifdef IRQ_TIMEOUT_EN
    task automatic test_timeout();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; irq_in = 1'b1; vec_in = 2'd1; mask = 4'b0000;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== {1'b1, 2'd1, 4'b0000, 1'b1, 1'b0}) begin
                errors++; $display("FAIL to_req[%0d]: got %b want %b", i, obs, {1'b1, 2'd1, 4'b0000, 1'b1, 1'b0});
            end
            step();
        end
        step();
        checks++;
        if (obs !== {1'b0, 2'd1, 4'b0000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL to_abort: got %b want %b", obs, {1'b0, 2'd1, 4'b0000, 1'b1, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {1'b0, 2'd1, 4'b0000, 1'b0, 1'b0}) begin
                errors++; $display("FAIL to_holdoff[%0d]: got %b want %b", i, obs, {1'b0, 2'd1, 4'b0000, 1'b0, 1'b0});
            end
        end
        step();
        checks++;
        if (obs !== {1'b1, 2'd1, 4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL to_rerequest: got %b want %b", obs, {1'b1, 2'd1, 4'b0000, 1'b1, 1'b0});
        end
        irq_in = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; irq_in = 1'b1; vec_in = 2'd1; mask = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            step();
            if (obs !== {1'b1, 2'd1, 4'b0000, 1'b1, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL no_timeout_hold: got %0d bad cycles want 0", bad);
        end
        irq_in = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_handshake();
        test_holdoff();
        test_simultaneous();
        test_stray();
        test_mask();
        test_reset_mid();
`ifdef IRQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
